// File: rtl/req_ack_pkg.sv
// req_ack_pkg: state encoding and default parameters shared by the req/ack requester and its checker
package req_ack_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP} state_e;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_TIMEOUT = 8;
    localparam int DEF_GAP     = 1;
    localparam int DEF_CNT_W   = 16;
endpackage

// File: rtl/req_ack_sva.sv
// req_ack_sva: concurrent assertions and covers for the req/ack requester (compiled in only with REQ_ACK_SVA_EN)
// Ports: clk, rst, state, ack, req, busy, done, timeout, spurious_ack, req_data (all observed, none driven).
module req_ack_sva
    import req_ack_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int GAP     = DEF_GAP
)(
    input logic              clk,
    input logic              rst,
    input state_e            state,
    input logic              ack,
    input logic              req,
    input logic              busy,
    input logic              done,
    input logic              timeout,
    input logic              spurious_ack,
    input logic [DATA_W-1:0] req_data
);
    a_rise_from_idle: assert property (@(posedge clk) disable iff (rst) $rose(req) |-> $past(state) == ST_IDLE);
    a_data_stable: assert property (@(posedge clk) disable iff (rst) req && $past(req) |-> $stable(req_data));
    a_bounded: assert property (@(posedge clk) disable iff (rst) $rose(req) |-> ##[1:TIMEOUT] (done || timeout));
    a_exclusive: assert property (@(posedge clk) disable iff (rst) !(done && timeout));
    a_busy_covers_req: assert property (@(posedge clk) disable iff (rst) req |-> busy);
    c_done: cover property (@(posedge clk) disable iff (rst) done);
    c_timeout: cover property (@(posedge clk) disable iff (rst) timeout);
    c_spurious: cover property (@(posedge clk) disable iff (rst) $rose(spurious_ack) && !ack);
    c_back_to_back: cover property (@(posedge clk) disable iff (rst) done ##[1:GAP+1] $rose(req));
endmodule

// File: rtl/req_ack_requester.sv
// req_ack_requester: single-outstanding req/ack requester with timeout, idle gap and completion counter
// Ports: clk, rst (sync, active-high); start/start_data command in; ack from responder;
//        busy, req, req_data, done, timeout, spurious_ack, txn_count registered outputs.
// Define REQ_ACK_SVA_EN to compile in the req_ack_sva checker.
module req_ack_requester
    import req_ack_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int GAP     = DEF_GAP,
    parameter int CNT_W   = DEF_CNT_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] start_data,
    input  logic              ack,
    output logic              busy,
    output logic              req,
    output logic [DATA_W-1:0] req_data,
    output logic              done,
    output logic              timeout,
    output logic              spurious_ack,
    output logic [CNT_W-1:0]  txn_count
);
    // one counter serves both the REQ wait and the GAP countdown
    localparam int MAXC = TIMEOUT > GAP ? TIMEOUT : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    state_e        state, nxt;
    logic [CW-1:0] cnt;
    logic          hit, expire, gap_end;
    always_comb begin
        hit     = state == ST_REQ && ack;
        expire  = state == ST_REQ && !ack && cnt == CW'(TIMEOUT - 1);
        gap_end = state == ST_GAP && cnt == CW'(GAP > 0 ? GAP - 1 : 0);
        nxt     = state == ST_IDLE ? (start ? ST_REQ : ST_IDLE)
                : (hit || expire)  ? (GAP > 0 ? ST_GAP : ST_IDLE)
                : gap_end          ? ST_IDLE
                : state;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            req          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            spurious_ack <= 1'b0;
            req_data     <= '0;
            txn_count    <= '0;
        end else begin
            state        <= nxt;
            cnt          <= (nxt != state || state == ST_IDLE) ? '0 : cnt + 1'b1;
            req          <= nxt == ST_REQ;
            busy         <= nxt != ST_IDLE;
            done         <= hit;
            timeout      <= expire;
            spurious_ack <= spurious_ack | (ack & ~req);
            if (state == ST_IDLE && start)
                req_data <= start_data;
            if (hit && txn_count != '1)
                txn_count <= txn_count + 1'b1;
        end
    end
`ifdef REQ_ACK_SVA_EN
    req_ack_sva #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .GAP(GAP)) u_sva (
        .clk(clk), .rst(rst), .state(state), .ack(ack), .req(req), .busy(busy),
        .done(done), .timeout(timeout), .spurious_ack(spurious_ack), .req_data(req_data)
    );
`else
`endif
endmodule

// File: tb/tb_req_ack_requester.sv
// tb_req_ack_requester: scoreboard bench for req_ack_requester (small CNT_W so saturation is reachable)
module tb_req_ack_requester;
    localparam int DW = 8;
    localparam int TO = 8;
    localparam int GP = 1;
    localparam int CW = 2;
    typedef struct {
        bit            is_done;
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
        int            len;
    } exp_t;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic [DW-1:0] start_data = '0;
    logic          busy, req, done, timeout, spurious_ack;
    logic [DW-1:0] req_data;
    logic [CW-1:0] txn_count;
    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    int            req_len = 0;
    int            exp_cnt = 0;
    always #5 clk = ~clk;
    req_ack_requester #(.DATA_W(DW), .TIMEOUT(TO), .GAP(GP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .start_data(start_data), .ack(ack),
        .busy(busy), .req(req), .req_data(req_data), .done(done), .timeout(timeout),
        .spurious_ack(spurious_ack), .txn_count(txn_count)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // k = req cycle (1-based) on which ack is driven; 0 = never ack
    task automatic txn(input logic [DW-1:0] d, input int k);
        start = 1'b1;
        start_data = d;
        step();
        start = 1'b0;
        chk("req_rise", 32'(req), 32'd1);
        chk("busy_rise", 32'(busy), 32'd1);
        if (k == 0) begin
            sb.push_back('{1'b0, d, CW'(exp_cnt), TO});
            repeat (TO) step();
        end else begin
            exp_cnt = exp_cnt < 3 ? exp_cnt + 1 : 3;
            sb.push_back('{1'b1, d, CW'(exp_cnt), k});
            repeat (k - 1) step();
            ack = 1'b1;
            step();
            ack = 1'b0;
        end
        repeat (GP + 1) step();
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_req"}, 32'(req), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_spurious"}, 32'(spurious_ack), 32'd0);
        chk({tag, "_req_data"}, 32'(req_data), 32'd0);
        chk({tag, "_txn_count"}, 32'(txn_count), 32'd0);
    endtask
    always @(negedge clk) begin
        if (rst) begin
            req_len = 0;
        end else begin
            if (done || timeout) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 32'({done, timeout}), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("completion_kind", 32'({done, timeout}), e.is_done ? 32'd2 : 32'd1);
                    chk("completion_data", 32'(req_data), 32'(e.data));
                    chk("completion_count", 32'(txn_count), 32'(e.cnt));
                    chk("req_high_cycles", 32'(req_len), 32'(e.len));
                end
                req_len = 0;
            end
            if (req) req_len++;
        end
    end
    initial begin
        repeat (2) step();
        chk_zero("reset");
        rst = 1'b0;
        step();
        txn(8'hA5, 3);
        chk("hold_req_data", 32'(req_data), 32'hA5);
        chk("count_after_done", 32'(txn_count), 32'd1);
        txn(8'h5A, 0);
        chk("count_after_timeout", 32'(txn_count), 32'd1);
        txn(8'hC3, TO);
        chk("count_after_last_cycle_ack", 32'(txn_count), 32'd2);
        chk("no_spurious_yet", 32'(spurious_ack), 32'd0);
        start = 1'b1;
        start_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            int lows;
            logic [DW-1:0] d;
            lows = 0;
            while (!req && lows < 10) begin
                lows++;
                step();
            end
            if (i > 0) chk("b2b_low_cycles", 32'(lows), 32'd2);
            d = 8'(8'h11 * (i + 1));
            chk("b2b_req_data", 32'(req_data), 32'(d));
            exp_cnt = exp_cnt < 3 ? exp_cnt + 1 : 3;
            sb.push_back('{1'b1, d, CW'(exp_cnt), 2});
            start_data = 8'(8'h11 * (i + 2));
            step();
            ack = 1'b1;
            step();
            ack = 1'b0;
            if (i == 2) start = 1'b0;
        end
        repeat (3) step();
        chk("count_saturated", 32'(txn_count), 32'd3);
        chk("idle_after_b2b", 32'(busy), 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        chk("spurious_set", 32'(spurious_ack), 32'd1);
        chk("spurious_no_req", 32'(req), 32'd0);
        chk("spurious_no_busy", 32'(busy), 32'd0);
        repeat (5) step();
        chk("spurious_sticky", 32'(spurious_ack), 32'd1);
        start = 1'b1;
        start_data = 8'h77;
        step();
        start = 1'b0;
        step();
        chk("mid_req_high", 32'(req), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_cnt = 0;
        chk_zero("mid_reset");
        repeat (2) step();
        txn(8'h3C, 2);
        chk("count_after_reset_txn", 32'(txn_count), 32'd1);
        chk("data_after_reset_txn", 32'(req_data), 32'h3C);
        repeat (3) step();
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
